// File: rtl/router_arb_pkg.sv
// Shared types and helpers for the router egress arbiter: FSM states, grant encoding,
// header length field and the egress buffer entry layout.
package router_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_WAIT = 2'd1,
    BODY     = 2'd2
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'd3;
  localparam int         HDR_LEN_HI = 7;
  localparam int         HDR_LEN_LO = 2;
  localparam int         ENTRY_W    = 11;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       perr;
  } obuf_entry_t;

  // Bytes still to read after the header: payload plus the parity byte.
  function automatic logic [6:0] hdr_rem(input logic [7:0] hdr);
    return {1'b0, hdr[HDR_LEN_HI:HDR_LEN_LO]} + 7'd1;
  endfunction

  // Round-robin pick: returns {found, port}, searching ptr+1, ptr+2, ptr (mod 3).
  function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
    logic [2:0] res;
    logic [1:0] p;
    res = {1'b0, GRANT_NONE};
    for (int k = 3; k >= 1; k--) begin
      p = 2'((int'(ptr) + k) % 3);
      if (req[p]) res = {1'b1, p};
    end
    return res;
  endfunction

endpackage

// File: rtl/router_arb_obuf.sv
// Small synchronous FIFO holding tagged egress bytes; head entry is presented
// combinationally so the egress link sees it without extra latency.
module router_arb_obuf
  import router_arb_pkg::*;
#(
  parameter int OBUF_DEPTH = 2,
  parameter int CNT_W      = $clog2(OBUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  obuf_entry_t       din,
  input  logic              pop,
  output obuf_entry_t       head,
  output logic [CNT_W-1:0]  count,
  output logic              empty
);

  localparam int AW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  obuf_entry_t      mem_q [OBUF_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(OBUF_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(OBUF_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/router_egress_arbiter.sv
// Packet-level round-robin drain of three router FIFOs onto one 8-bit egress link.
// Optional mid-packet abort on FIFO starvation: define ROUTER_ARB_TIMEOUT_EN.
module router_egress_arbiter
  import router_arb_pkg::*;
#(
  parameter int OBUF_DEPTH  = 2,
  parameter int TIMEOUT_CYC = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_out_0,
  input  logic       valid_out_1,
  input  logic       valid_out_2,
  input  logic [7:0] data_out_0,
  input  logic [7:0] data_out_1,
  input  logic [7:0] data_out_2,
  output logic       read_enb_0,
  output logic       read_enb_1,
  output logic       read_enb_2,
  output logic [7:0] eg_data,
  output logic       eg_valid,
  input  logic       eg_ready,
  output logic       eg_sop,
  output logic       eg_eop,
  output logic       eg_perr,
  output logic [1:0] grant
);

  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [6:0]       rem_q, rem_d;
  logic             inflight_q, inflight_d;
  logic [1:0]       fl_port_q, fl_port_d;
  logic             fl_sop_q, fl_sop_d;
  logic             fl_eop_q, fl_eop_d;
  logic [7:0]       par_q, par_d;

  logic [3:0]       req;
  logic [2:0]       pick;
  logic [7:0]       land_data, par_next;
  logic [CNT_W-1:0] occ;
  logic             empty, pop, push, credit, issue;
  logic [1:0]       issue_port;
  logic [2:0]       rd_en;
  logic             tmo_hit, synth_push;
  obuf_entry_t      head, push_entry;

  assign req = {1'b0, valid_out_2, valid_out_1, valid_out_0};
  assign pop = !empty && eg_ready;

  // Reads in flight (issued last cycle) land this cycle, so they count against space.
  assign credit = eg_ready &&
                  ((int'(occ) - int'(pop) + int'(inflight_q)) < OBUF_DEPTH);

  always_comb begin
    case (fl_port_q)
      2'd0:    land_data = data_out_0;
      2'd1:    land_data = data_out_1;
      default: land_data = data_out_2;
    endcase
  end

`ifdef ROUTER_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_hit    = (state_q == BODY) && (tmo_q == TMO_W'(TIMEOUT_CYC));
  assign synth_push = tmo_hit && !inflight_q &&
                      ((int'(occ) - int'(pop)) < OBUF_DEPTH);

  always_comb begin
    tmo_d = tmo_q;
    if (state_q != BODY || issue || synth_push) tmo_d = '0;
    else if (!tmo_hit)                          tmo_d = tmo_q + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  // Feature compiled out: BODY simply waits for the FIFO to refill.
  assign tmo_hit    = (TIMEOUT_CYC < 0);
  assign synth_push = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    issue      = 1'b0;
    issue_port = grant_q;
    fl_sop_d   = 1'b0;
    fl_eop_d   = 1'b0;
    pick       = rr_pick(ptr_q, req);
    case (state_q)
      IDLE: begin
        if (pick[2] && credit) begin
          issue      = 1'b1;
          issue_port = pick[1:0];
          grant_d    = pick[1:0];
          ptr_d      = pick[1:0];
          fl_sop_d   = 1'b1;
          state_d    = HDR_WAIT;
        end
      end
      HDR_WAIT: begin
        rem_d   = hdr_rem(land_data);
        state_d = BODY;
      end
      BODY: begin
        if (!tmo_hit && req[grant_q] && credit && rem_q != '0) begin
          issue = 1'b1;
          rem_d = rem_q - 7'd1;
          if (rem_q == 7'd1) begin
            fl_eop_d = 1'b1;
            state_d  = IDLE;
            grant_d  = GRANT_NONE;
          end
        end else if (synth_push) begin
          state_d = IDLE;
          grant_d = GRANT_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign inflight_d = issue;
  assign fl_port_d  = issue_port;
  assign rd_en      = (issue && !rst) ? (3'b001 << issue_port) : 3'b000;

  // Landing stage: byte returns from the FIFO, parity accumulates, entry is pushed.
  assign par_next = fl_sop_q ? land_data : (par_q ^ land_data);
  assign par_d    = inflight_q ? par_next : par_q;
  assign push     = inflight_q || synth_push;

  always_comb begin
    if (synth_push) begin
      push_entry = '{data: 8'h00, sop: 1'b0, eop: 1'b1, perr: 1'b1};
    end else begin
      push_entry = '{data: land_data, sop: fl_sop_q, eop: fl_eop_q,
                     perr: fl_eop_q && (par_next != 8'h00)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= GRANT_NONE;
      ptr_q      <= 2'd2;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      fl_port_q  <= '0;
      fl_sop_q   <= 1'b0;
      fl_eop_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      fl_port_q  <= fl_port_d;
      fl_sop_q   <= fl_sop_d;
      fl_eop_q   <= fl_eop_d;
    end
  end

  always_ff @(posedge clk) begin
    par_q <= par_d;
  end

  router_arb_obuf #(
    .OBUF_DEPTH (OBUF_DEPTH),
    .CNT_W      (CNT_W)
  ) u_obuf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head),
    .count (occ),
    .empty (empty)
  );

  assign read_enb_0 = rd_en[0];
  assign read_enb_1 = rd_en[1];
  assign read_enb_2 = rd_en[2];
  assign eg_valid   = !empty;
  assign eg_data    = empty ? 8'h00 : head.data;
  assign eg_sop     = !empty && head.sop;
  assign eg_eop     = !empty && head.eop;
  assign eg_perr    = !empty && head.perr;
  assign grant      = grant_q;

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Directed bench for router_egress_arbiter: behavioural router FIFOs feed the ports,
// egress beats are logged and compared against hand-computed byte streams.
module tb_router_egress_arbiter;

  localparam int OBUF_DEPTH  = 2;
  localparam int TIMEOUT_CYC = 24;

  logic       clk = 1'b0;
  logic       rst;
  logic       eg_ready;
  logic       valid_out_0, valid_out_1, valid_out_2;
  logic       read_enb_0, read_enb_1, read_enb_2;
  logic [7:0] eg_data;
  logic       eg_valid, eg_sop, eg_eop, eg_perr;
  logic [1:0] grant;

  always #5 clk = ~clk;

  // Router FIFO model: one-cycle read latency after read_enb.
  logic [7:0] fmem [3][64];
  int         wr_ptr [3] = '{0, 0, 0};
  int         rd_ptr [3] = '{0, 0, 0};
  int         rd_cnt [3] = '{0, 0, 0};
  logic       hold   [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] dout   [3];
  logic       flush = 1'b0;
  logic [2:0] rd_vec;

  assign rd_vec      = {read_enb_2, read_enb_1, read_enb_0};
  assign valid_out_0 = (wr_ptr[0] != rd_ptr[0]) && !hold[0];
  assign valid_out_1 = (wr_ptr[1] != rd_ptr[1]) && !hold[1];
  assign valid_out_2 = (wr_ptr[2] != rd_ptr[2]) && !hold[2];

  always @(posedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (flush) begin
        rd_ptr[p] <= wr_ptr[p];
      end else if (rd_vec[p]) begin
        dout[p]   <= fmem[p][rd_ptr[p] % 64];
        rd_ptr[p] <= rd_ptr[p] + 1;
        rd_cnt[p] <= rd_cnt[p] + 1;
      end
    end
  end

  // Egress log: a beat seen here transfers on the following rising edge.
  logic [7:0] b_data [256];
  logic       b_sop  [256];
  logic       b_eop  [256];
  logic       b_perr [256];
  int         nb = 0;

  always @(negedge clk) begin
    if (eg_valid && eg_ready && nb < 256) begin
      b_data[nb] <= eg_data;
      b_sop[nb]  <= eg_sop;
      b_eop[nb]  <= eg_eop;
      b_perr[nb] <= eg_perr;
      nb         <= nb + 1;
    end
  end

  router_egress_arbiter #(
    .OBUF_DEPTH  (OBUF_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .valid_out_2 (valid_out_2),
    .data_out_0  (dout[0]),
    .data_out_1  (dout[1]),
    .data_out_2  (dout[2]),
    .read_enb_0  (read_enb_0),
    .read_enb_1  (read_enb_1),
    .read_enb_2  (read_enb_2),
    .eg_data     (eg_data),
    .eg_valid    (eg_valid),
    .eg_ready    (eg_ready),
    .eg_sop      (eg_sop),
    .eg_eop      (eg_eop),
    .eg_perr     (eg_perr),
    .grant       (grant)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input int p, input logic [7:0] b);
    fmem[p][wr_ptr[p] % 64] = b;
    wr_ptr[p] = wr_ptr[p] + 1;
  endtask

  task automatic push_pkt(input int p, input logic [7:0] bytes [$]);
    foreach (bytes[i]) push_byte(p, bytes[i]);
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int k = 0;
    while (nb < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, nb, target);
  endtask

  task automatic check_stream(input string tag, input int base, input logic [7:0] exp [$]);
    foreach (exp[i]) check_val($sformatf("%s_b%0d", tag, i), b_data[base + i], exp[i]);
  endtask

  // which: 0 = sop, 1 = eop, 2 = perr; bit i of the result is beat base+i.
  function automatic logic [15:0] flags(input int base, input int n, input int which);
    logic [15:0] v = '0;
    for (int i = 0; i < n; i++) begin
      case (which)
        0:       v[i] = b_sop[base + i];
        1:       v[i] = b_eop[base + i];
        default: v[i] = b_perr[base + i];
      endcase
    end
    return v;
  endfunction

  task automatic reset_dut();
    rst   = 1'b1;
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, rbase, k, buffered;
    logic       bad_rd, bad_hold, bad_grant;
    logic [7:0] held;

    rst      = 1'b1;
    eg_ready = 1'b1;
    flush    = 1'b1;
    cyc(2);
    flush = 1'b0;

    // Reset values, with a packet already waiting on port 1.
    push_pkt(1, '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D});
    #2;
    check_val("rst_outputs", {eg_valid, eg_sop, eg_eop, eg_perr, eg_data}, 12'h000);
    check_val("rst_grant", grant, 2'd3);
    check_val("rst_rd_forced_off", rd_vec, 3'b000);

    // Single packet on port 1.
    @(posedge clk); #1;
    base  = nb;
    rbase = rd_cnt[1];
    rst   = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!read_enb_1 && k < 10);
    check_val("t1_hdr_rd", read_enb_1, 1'b1);
    @(negedge clk);
    check_val("t1_gap_rd", read_enb_1, 1'b0);
    check_val("t1_grant", grant, 2'd1);
    @(negedge clk);
    check_val("t1_body_rd", read_enb_1, 1'b1);
    wait_beats(base + 5, 40, "t1_beats");
    check_stream("t1", base, '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D});
    check_val("t1_sop", flags(base, 5, 0), 16'b00001);
    check_val("t1_eop", flags(base, 5, 1), 16'b10000);
    check_val("t1_perr", flags(base, 5, 2), 16'b00000);
    check_val("t1_rd_count", rd_cnt[1] - rbase, 5);
    @(negedge clk);
    check_val("t1_grant_none", grant, 2'd3);

    // Round robin: all three ports request at once after reset.
    @(posedge clk); #1;
    reset_dut();
    push_pkt(0, '{8'h08, 8'hA1, 8'hA2, 8'h0B});
    push_pkt(1, '{8'h08, 8'hB1, 8'hB2, 8'h0B});
    push_pkt(2, '{8'h08, 8'hC1, 8'hC2, 8'h0B});
    base = nb;
    rst  = 1'b0;
    wait_beats(base + 12, 80, "t2_beats");
    check_stream("t2", base, '{8'h08, 8'hA1, 8'hA2, 8'h0B, 8'h08, 8'hB1, 8'hB2, 8'h0B,
                               8'h08, 8'hC1, 8'hC2, 8'h0B});
    check_val("t2_eop", flags(base, 12, 1), 16'b1000_1000_1000);
    @(posedge clk); #1;
    base = nb;
    push_pkt(0, '{8'h08, 8'hD1, 8'hD2, 8'h0B});
    wait_beats(base + 4, 40, "t2_p0_beats");
    check_val("t2_p0_byte", b_data[base + 1], 8'hD1);
    @(posedge clk); #1;
    base = nb;
    push_pkt(0, '{8'h08, 8'h51, 8'h52, 8'h0B});
    push_pkt(1, '{8'h08, 8'h61, 8'h62, 8'h0B});
    push_pkt(2, '{8'h08, 8'h71, 8'h72, 8'h0B});
    wait_beats(base + 12, 80, "t2_r3_beats");
    check_val("t2_r3_first", b_data[base + 1], 8'h61);
    check_val("t2_r3_second", b_data[base + 5], 8'h71);
    check_val("t2_r3_third", b_data[base + 9], 8'h51);

    // Backpressure mid-packet on port 0.
    @(posedge clk); #1;
    base  = nb;
    rbase = rd_cnt[0];
    push_pkt(0, '{8'h10, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h10});
    wait_beats(base + 2, 40, "t3_pre_beats");
    @(posedge clk); #1;
    eg_ready  = 1'b0;
    bad_rd    = 1'b0;
    bad_hold  = 1'b0;
    @(negedge clk);
    held = eg_data;
    for (int i = 0; i < 10; i++) begin
      if (read_enb_0) bad_rd = 1'b1;
      if (!eg_valid || eg_data != held) bad_hold = 1'b1;
      @(negedge clk);
    end
    buffered = (rd_cnt[0] - rbase) - (nb - base);
    check_val("t3_rd_blocked", bad_rd, 1'b0);
    check_val("t3_data_held", bad_hold, 1'b0);
    check_val("t3_buffered_le_depth", buffered <= OBUF_DEPTH, 1'b1);
    @(posedge clk); #1;
    eg_ready = 1'b1;
    wait_beats(base + 6, 40, "t3_beats");
    check_stream("t3", base, '{8'h10, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h10});
    check_val("t3_eop", flags(base, 6, 1), 16'b100000);
    check_val("t3_rd_count", rd_cnt[0] - rbase, 6);

    // FIFO gap on port 2 during the payload.
    @(posedge clk); #1;
    base  = nb;
    rbase = rd_cnt[2];
    push_pkt(2, '{8'h0C, 8'h21, 8'h42, 8'h84, 8'hEB});
    k = 0;
    do begin @(negedge clk); k++; end while ((rd_cnt[2] - rbase) < 2 && k < 20);
    check_val("t4_reads_before_gap", rd_cnt[2] - rbase, 2);
    hold[2]   = 1'b1;
    bad_rd    = 1'b0;
    bad_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (read_enb_2) bad_rd = 1'b1;
      if (grant != 2'd2) bad_grant = 1'b1;
    end
    hold[2] = 1'b0;
    check_val("t4_rd_stalled", bad_rd, 1'b0);
    check_val("t4_grant_kept", bad_grant, 1'b0);
    wait_beats(base + 5, 40, "t4_beats");
    check_stream("t4", base, '{8'h0C, 8'h21, 8'h42, 8'h84, 8'hEB});
    check_val("t4_eop", flags(base, 5, 1), 16'b10000);
    check_val("t4_perr", flags(base, 5, 2), 16'b00000);

    // Corrupted parity byte on port 1 (correct value would be 8'h73).
    @(posedge clk); #1;
    base = nb;
    push_pkt(1, '{8'h04, 8'h77, 8'h72});
    wait_beats(base + 3, 40, "t5_beats");
    check_stream("t5", base, '{8'h04, 8'h77, 8'h72});
    check_val("t5_perr", flags(base, 3, 2), 16'b100);
    check_val("t5_eop", flags(base, 3, 1), 16'b100);

    // Reset asserted mid-packet: outputs return to reset values at once.
    @(posedge clk); #1;
    base = nb;
    push_pkt(0, '{8'h10, 8'h01, 8'h02, 8'h03, 8'h04, 8'h14});
    wait_beats(base + 2, 40, "t6_pre_beats");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_val("t6_rst_outputs", {eg_valid, eg_sop, eg_eop, eg_perr, eg_data}, 12'h000);
    check_val("t6_rst_grant", grant, 2'd3);
    check_val("t6_rst_rd", read_enb_0, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    base  = nb;
    rst   = 1'b0;
    cyc(5);
    check_val("t6_no_beats_after", nb, base);

`ifdef ROUTER_ARB_TIMEOUT_EN
    // Port 0 starves mid-packet: synthetic aborted eop after the timeout.
    base = nb;
    push_pkt(0, '{8'h0C, 8'h99});
    wait_beats(base + 3, 100, "t7_beats");
    check_stream("t7", base, '{8'h0C, 8'h99, 8'h00});
    check_val("t7_eop", flags(base, 3, 1), 16'b100);
    check_val("t7_perr", flags(base, 3, 2), 16'b100);
    @(negedge clk);
    check_val("t7_grant_none", grant, 2'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_egress_arbiter.md
Name: router_egress_arbiter

Overview:
- Drains the three router output FIFOs onto a single 8-bit egress link toward the host or downstream fabric.
- Arbitration is round-robin per packet: the owning port is held from header to parity byte, so packets never interleave.
- Drives read_enb_0/1/2 from valid_out_0/1/2, parses the header length to find the packet end, tags sop/eop, and checks parity on the fly.
- Sits beside the router top, between its output ports and the egress consumer.

Parameters:
- OBUF_DEPTH, 2, entries in the egress output buffer (minimum 2; absorbs the 1-cycle FIFO read latency).
- TIMEOUT_CYC, 24, idle cycles mid-packet before abort (optional feature only); must stay below the router FIFO soft-reset window of 30.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- valid_out_0, valid_out_1, valid_out_2  in  1  router FIFO n non-empty
- data_out_0, data_out_1, data_out_2  in  8  router FIFO n read data; valid the cycle after read_enb_n
- read_enb_0, read_enb_1, read_enb_2  out  1  pop strobe to router FIFO n
- eg_data  out  8  egress byte
- eg_valid  out  1  egress byte valid
- eg_ready  in  1  downstream accepts; a beat transfers when eg_valid && eg_ready
- eg_sop  out  1  beat is a header byte
- eg_eop  out  1  beat is a parity byte
- eg_perr  out  1  valid on eop beats: XOR of all packet bytes != 0
- grant  out  2  current owner 0..2; 3 = none

Behaviour:
- Reset (asynchronous): state IDLE, grant=3, rr pointer=2 (port 0 wins first), buffer empty.
  - All outputs 0, except grant=3.
  - read_enb_n is forced 0 while rst is high.
- read_enb_n is combinational from registered state plus valid_out_n and credit.
  - Only the granted port's read_enb may be high.
  - read_enb is never high when its valid_out is low.
- Credit: a read may issue only if buffer occupancy + in-flight reads (0 or 1) < OBUF_DEPTH.
  - Occupancy counts a pop occurring in the same cycle.
- Read latency: byte issued at cycle t is written into the buffer at t+1, together with its sop/eop tags latched at issue.
- FSM states:
  - IDLE: if any valid_out and credit, pick the first requester after the rr pointer (order ptr+1, ptr+2, ptr mod 3). Set grant and the pointer, assert read_enb for the header in the same cycle, tag sop, go to HDR_WAIT.
  - HDR_WAIT: the header lands. Load rem = data[7:2] + 1 (payload plus parity; length 0 gives rem = 1). Go to BODY. No read issues in this cycle.
  - BODY: read issues when valid_out_g && credit && rem != 0, and rem decrements on each issue. The issue with rem==1 is tagged eop; after it, go to IDLE with grant=3.
- Back-to-back packets: in the cycle after the final issue, IDLE may grant again, including to the same port if it still wins round-robin.
- FIFO empty mid-packet (valid_out_g low): stall in BODY with no read. Resume when valid_out_g returns.
- Buffer full or eg_ready low: no issue. Egress data, sop, eop and perr are held stable while eg_valid && !eg_ready.
- Parity: a running XOR is cleared on the sop beat at buffer write, accumulates every landed byte, and is registered into that entry's perr tag on eop.
- rem width is 7 bits, so max rem is 64. No wrap-around.

Optional Feature:
- Macro: ROUTER_ARB_TIMEOUT_EN.
- With the macro defined: a counter increments in BODY for every cycle with no issue and clears on each issue.
  - When it reaches TIMEOUT_CYC, a synthetic byte 8'h00 is pushed (once buffer space allows) with eop=1 and perr=1.
  - The FSM then returns to IDLE, grant=3, and the counter clears.
  - Residual bytes of that packet are later seen as a new header. This is acceptable because the router soft-reset flushes them.
- Without the macro: no counter; BODY stalls indefinitely.

Decomposition:
- Package router_arb_pkg holds:
  - the state enum (IDLE, HDR_WAIT, BODY)
  - GRANT_NONE = 2'd3
  - the header length field slice [7:2]
  - the buffer entry width (8 data + sop + eop + perr = 11 bits)
- Sub-module router_arb_obuf: an OBUF_DEPTH x 11-bit synchronous FIFO with push/pop/count. It presents head entry outputs and takes the same clk and rst.

Test Plan:
- Single packet on port 1: header 8'h0D (len 3), 3 payload bytes, parity = XOR; eg_ready=1 -> read_enb_1 for 5 cycles (one-cycle gap after the header), grant=1, eg_sop on 8'h0D, eg_eop on the parity beat, eg_perr=0.
- All three ports valid at once, each with len 2, after reset -> egress order is port 0, 1, 2. The next round after another port-0 packet goes to port 1.
- Backpressure: eg_ready low for 10 cycles mid-packet -> at most OBUF_DEPTH bytes buffered, read_enb stays 0, eg_data held stable, no byte lost or duplicated.
- FIFO gap: valid_out_2 drops for 4 cycles during the payload -> read_enb_2 stays 0, grant stays 2, the packet resumes and completes with a correct eop.
- Corrupt parity byte (expected ^ 8'h01) -> eg_perr=1 on the eop beat only.
- ROUTER_ARB_TIMEOUT_EN defined, valid_out_0 dropped mid-packet for TIMEOUT_CYC cycles -> one beat 8'h00 with eop=1 and perr=1, then grant=3. Assert rst mid-packet -> all outputs return to reset values immediately.
